fetch_pc_gen: RTL and testbench
===============================

Name: fetch_pc_gen

Overview:
Fetch-stage next-PC generator that sits directly downstream of the branch target buffer. Each cycle it picks the next fetch PC: the BTB prediction when one is present, otherwise sequential PC+4. It records every prediction in an in-order queue. When the execute stage resolves an instruction, the block compares the real next PC with the queued prediction; on a mismatch it flushes the pipe and redirects fetch. It also drives current_pc/prev_pc back into the BTB.

Parameters:
RESET_PC, 64'h0, fetch address loaded on reset
DEPTH, 4, prediction queue entries (power of two, 2..16)
CNT_W, 16, width of the saturating mispredict counter

Ports:
clk  input  1  clock, all state on rising edge
arst_n  input  1  asynchronous active-low reset
en  input  1  pipeline enable; low = fetch stall, queue resolution still allowed
predicted_branch_pc  input  64  BTB target for current_pc this cycle; 0 = no prediction
resolve_valid  input  1  execute stage resolves the oldest in-flight instruction
resolve_next_pc  input  64  architecturally correct next PC of that instruction
current_pc  output  64  PC being fetched this cycle
prev_pc  output  64  PC of the last instruction pushed into the queue
fetch_valid  output  1  current_pc fetch is accepted this cycle
flush  output  1  one-cycle pulse: squash younger instructions
queue_full  output  1  count == DEPTH
queue_count  output  $clog2(DEPTH)+1  entries in flight
mispredict_count  output  CNT_W  saturating count of mispredictions

Behaviour:
- Reset (arst_n=0, asynchronous):
  - current_pc=RESET_PC; prev_pc=0
  - queue cleared: count=0, rd/wr pointers=0
  - flush=0; mispredict_count=0; state=FETCH
- pred_next = (predicted_branch_pc != 0) ? predicted_branch_pc : current_pc+4
  - 64-bit add, wraps modulo 2^64
- fetch_valid = (state==FETCH) && en && !queue_full && !mispredict_now
  - combinational
  - mispredict_now = resolve_valid && count!=0 && resolve_next_pc != queue[rd]
- Push, on fetch_valid:
  - queue[wr] <= pred_next; wr++ (wraps at DEPTH)
  - prev_pc <= current_pc; current_pc <= pred_next
- Pop, on resolve_valid && count!=0:
  - rd++
  - if mispredict_now:
    - whole queue cleared (count=0, rd=wr=0)
    - current_pc <= resolve_next_pc
    - flush <= 1 for exactly the next cycle
    - mispredict_count++ (saturates at all-ones)
    - state <= REDIRECT
- resolve_valid with count==0: ignored, no state change.
- Simultaneous push and correct pop: count unchanged, both pointers advance.
  - Allowed when full, because a pop frees an entry in the same cycle? No: fetch_valid uses the pre-pop queue_full, so push is blocked when full.
- Mispredict has priority over push: the same-cycle fetch is discarded and prev_pc is not updated.
- State machine:
  - FETCH: normal operation.
  - REDIRECT: lasts one cycle (flush high); no push, no pop accepted (resolve_valid ignored); then returns to FETCH unconditionally.
- en=0: current_pc, prev_pc and the write side hold; pops and mispredicts still processed.
- Queue full: fetch stalls; current_pc holds until a pop frees an entry.
- Reset mid-operation: immediate return to reset values; no flush pulse is generated by reset.
- Latency:
  - redirect PC appears on current_pc the cycle after the mismatching resolve
  - first fetch of the redirect target is accepted 2 cycles after the resolve (one REDIRECT bubble)

Test Plan:
- Reset, then en=1, predicted_branch_pc=0, no resolves -> current_pc 0,4,8,12, then holds at 16 with queue_full=1, queue_count=4, fetch_valid=0.
- At current_pc=8 drive predicted_branch_pc=64'h100 -> next current_pc=64'h100, prev_pc=8; later resolve with resolve_next_pc=64'h100 -> no flush, mispredict_count stays 0.
- Queue holds prediction 12; resolve_valid with resolve_next_pc=64'h200 -> flush=1 next cycle, current_pc=64'h200, queue_count=0, mispredict_count=1; a resolve_valid in the REDIRECT cycle is ignored; fetch_valid returns the cycle after.
- Steady state with push and correct pop each cycle, count=2 -> count stays 2, pointers wrap past DEPTH-1 without error.
- resolve_valid on empty queue and en=0 for 3 cycles -> no change to any output; current_pc=64'hFFFF_FFFF_FFFF_FFFC with no prediction -> next current_pc=0.
- Assert arst_n low mid-run with count=3 and flush pending -> current_pc=RESET_PC, count=0, flush=0, mispredict_count=0 immediately, without waiting for a clock edge; with CNT_W=2, force 5 mispredicts -> mispredict_count saturates at 3.

Source files
------------

// File: rtl/fetch_pc_gen_if.sv
// rtl/fetch_pc_gen_if.sv - fetch/resolve bundle between BTB, execute and the next-PC generator
interface fetch_pc_gen_if #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
);
  logic                   en;
  logic [63:0]            predicted_branch_pc;
  logic                   resolve_valid;
  logic [63:0]            resolve_next_pc;
  logic [63:0]            current_pc;
  logic [63:0]            prev_pc;
  logic                   fetch_valid;
  logic                   flush;
  logic                   queue_full;
  logic [$clog2(DEPTH):0] queue_count;
  logic [CNT_W-1:0]       mispredict_count;

  modport master (
    output en, predicted_branch_pc, resolve_valid, resolve_next_pc,
    input  current_pc, prev_pc, fetch_valid, flush, queue_full, queue_count, mispredict_count
  );

  modport slave (
    input  en, predicted_branch_pc, resolve_valid, resolve_next_pc,
    output current_pc, prev_pc, fetch_valid, flush, queue_full, queue_count, mispredict_count
  );
endinterface

// File: rtl/fetch_pc_gen.sv
// rtl/fetch_pc_gen.sv - next fetch PC selection with in-order prediction queue and mispredict redirect
module fetch_pc_gen #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int          DEPTH    = 4,
  parameter int          CNT_W    = 16
) (
  input logic           clk,
  input logic           arst_n,
  fetch_pc_gen_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam logic [PTR_W-1:0] PTR_ONE = 1;
  localparam logic [CW-1:0]    CNT_ONE = 1;
  localparam logic [CNT_W-1:0] MIS_ONE = 1;

  typedef enum logic {FETCH, REDIRECT} state_t;

  state_t           state;
  logic [63:0]      queue [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CW-1:0]    count;
  logic [63:0]      cur_pc;
  logic [63:0]      last_pc;
  logic             flush_r;
  logic [CNT_W-1:0] mis_cnt;

  logic             full;
  logic             pop;
  logic             push;
  logic             mispredict_now;
  logic [63:0]      pred_next;

  assign full           = (count == CW'(DEPTH));
  assign pred_next      = (bus.predicted_branch_pc != 64'd0) ? bus.predicted_branch_pc
                                                             : cur_pc + 64'd4;
  assign pop            = (state == FETCH) && bus.resolve_valid && (count != '0);
  assign mispredict_now = pop && (bus.resolve_next_pc != queue[rd_ptr]);
  // push uses the pre-pop full flag, so a full queue never pushes even on a pop
  assign push           = (state == FETCH) && bus.en && !full && !mispredict_now;

  assign bus.current_pc       = cur_pc;
  assign bus.prev_pc          = last_pc;
  assign bus.fetch_valid      = push;
  assign bus.flush            = flush_r;
  assign bus.queue_full       = full;
  assign bus.queue_count      = count;
  assign bus.mispredict_count = mis_cnt;

  always_ff @(posedge clk) begin
    if (push) begin
      queue[wr_ptr] <= pred_next;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state   <= FETCH;
      cur_pc  <= RESET_PC;
      last_pc <= '0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      flush_r <= 1'b0;
      mis_cnt <= '0;
    end else begin
      flush_r <= 1'b0;
      case (state)
        FETCH: begin
          if (mispredict_now) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            cur_pc  <= bus.resolve_next_pc;
            flush_r <= 1'b1;
            if (mis_cnt != '1) begin
              mis_cnt <= mis_cnt + MIS_ONE;
            end
            state   <= REDIRECT;
          end else begin
            if (push) begin
              wr_ptr  <= wr_ptr + PTR_ONE;
              last_pc <= cur_pc;
              cur_pc  <= pred_next;
            end
            if (pop) begin
              rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (push && !pop) begin
              count <= count + CNT_ONE;
            end else if (!push && pop) begin
              count <= count - CNT_ONE;
            end
          end
        end
        REDIRECT: begin
          state <= FETCH;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_pc_gen.sv
// tb/tb_fetch_pc_gen.sv - scoreboard bench for fetch_pc_gen against a queue-level reference model
module tb_fetch_pc_gen;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic arst_n = 1'b0;
  always #5 clk = ~clk;

  fetch_pc_gen_if #(.DEPTH(DEPTH), .CNT_W(16)) bus ();
  fetch_pc_gen_if #(.DEPTH(2), .CNT_W(2)) bus2 ();

  fetch_pc_gen #(.RESET_PC(64'h0), .DEPTH(DEPTH), .CNT_W(16)) dut (
    .clk(clk), .arst_n(arst_n), .bus(bus)
  );
  fetch_pc_gen #(.RESET_PC(64'h0), .DEPTH(2), .CNT_W(2)) dut2 (
    .clk(clk), .arst_n(arst_n), .bus(bus2)
  );

  typedef struct {
    logic [63:0] cur;
    logic [63:0] prev;
    bit          fv;
    bit          fl;
    bit          full;
    int          cnt;
    int          mis;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_x;
  int          checks = 0;
  int          failures = 0;

  logic [63:0] m_pc;
  logic [63:0] m_prev;
  logic [63:0] m_q[$];
  bit          m_redirect;
  bit          m_flush;
  int          m_mis;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  function automatic void model_reset();
    m_pc = 64'h0;
    m_prev = 64'h0;
    m_q.delete();
    m_redirect = 1'b0;
    m_flush = 1'b0;
    m_mis = 0;
  endfunction

  function automatic logic [63:0] head();
    return (m_q.size() > 0) ? m_q[0] : 64'h1234_5678_9ABC_DEF1;
  endfunction

  task automatic step(input bit e, input logic [63:0] p, input bit r, input logic [63:0] n);
    exp_t x;
    bit mis;
    bit fv;
    logic [63:0] pred;
    @(posedge clk);
    #1;
    bus.en = e;
    bus.predicted_branch_pc = p;
    bus.resolve_valid = r;
    bus.resolve_next_pc = n;
    mis = !m_redirect && r && (m_q.size() > 0) && (n != m_q[0]);
    fv  = !m_redirect && e && (m_q.size() < DEPTH) && !mis;
    x.cur = m_pc; x.prev = m_prev; x.fv = fv; x.fl = m_flush;
    x.full = (m_q.size() == DEPTH); x.cnt = m_q.size(); x.mis = m_mis;
    exp_q.push_back(x);
    pred = (p != 64'h0) ? p : m_pc + 64'd4;
    m_flush = 1'b0;
    if (m_redirect) begin
      m_redirect = 1'b0;
    end else if (mis) begin
      m_q.delete();
      m_pc = n;
      m_flush = 1'b1;
      m_redirect = 1'b1;
      if (m_mis < 65535) m_mis++;
    end else begin
      if (r && m_q.size() > 0) void'(m_q.pop_front());
      if (fv) begin
        m_q.push_back(pred);
        m_prev = m_pc;
        m_pc = pred;
      end
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    bus.en = 1'b0; bus.resolve_valid = 1'b0; bus.predicted_branch_pc = '0; bus.resolve_next_pc = '0;
    arst_n = 1'b0;
    #2;
    arst_n = 1'b1;
    model_reset();
  endtask

  // Reset asserted mid-cycle; outputs must clear before any clock edge.
  task automatic mid_reset();
    @(posedge clk);
    #1;
    bus.en = 1'b0; bus.resolve_valid = 1'b0;
    check("pre_reset_flush", {63'h0, bus.flush}, {63'h0, m_flush});
    check("pre_reset_count", 64'(bus.queue_count), 64'(m_q.size()));
    #2;
    arst_n = 1'b0;
    #1;
    check("async_current_pc", bus.current_pc, 64'h0);
    check("async_prev_pc", bus.prev_pc, 64'h0);
    check("async_count", 64'(bus.queue_count), 64'h0);
    check("async_flush", {63'h0, bus.flush}, 64'h0);
    check("async_mispredict_count", 64'(bus.mispredict_count), 64'h0);
    model_reset();
    @(posedge clk);
    #1;
    arst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_x = exp_q.pop_front();
      check("current_pc", bus.current_pc, mon_x.cur);
      check("prev_pc", bus.prev_pc, mon_x.prev);
      check("fetch_valid", {63'h0, bus.fetch_valid}, {63'h0, mon_x.fv});
      check("flush", {63'h0, bus.flush}, {63'h0, mon_x.fl});
      check("queue_full", {63'h0, bus.queue_full}, {63'h0, mon_x.full});
      check("queue_count", 64'(bus.queue_count), 64'(mon_x.cnt));
      check("mispredict_count", 64'(bus.mispredict_count), 64'(mon_x.mis));
    end
  end

  initial begin
    logic [63:0] p;
    logic [63:0] n;
    bus.en = 1'b0; bus.predicted_branch_pc = '0; bus.resolve_valid = 1'b0; bus.resolve_next_pc = '0;
    bus2.en = 1'b0; bus2.predicted_branch_pc = '0; bus2.resolve_valid = 1'b0; bus2.resolve_next_pc = '0;
    model_reset();
    #22;
    arst_n = 1'b1;

    // sequential fill until the queue is full
    for (int i = 0; i < 7; i++) step(1, 64'h0, 0, 64'h0);

    // BTB hit at pc 8 then correct resolves
    do_reset();
    step(1, 64'h0, 0, 64'h0);
    step(1, 64'h0, 0, 64'h0);
    step(1, 64'h100, 0, 64'h0);
    for (int i = 0; i < 3; i++) step(0, 64'h0, 1, head());
    step(0, 64'h0, 0, 64'h0);

    // mispredict on queued 12, resolve during REDIRECT ignored
    do_reset();
    for (int i = 0; i < 3; i++) step(1, 64'h0, 0, 64'h0);
    step(0, 64'h0, 1, head());
    step(0, 64'h0, 1, head());
    step(1, 64'h0, 1, 64'h200);
    step(1, 64'h0, 1, 64'h300);
    for (int i = 0; i < 3; i++) step(1, 64'h0, 0, 64'h0);

    // steady push plus correct pop at count 2, wrapping pointers
    do_reset();
    step(1, 64'h0, 0, 64'h0);
    step(1, 64'h0, 0, 64'h0);
    for (int i = 0; i < 10; i++) step(1, 64'h0, 1, head());

    // empty-queue resolve while stalled, then PC wrap
    do_reset();
    for (int i = 0; i < 3; i++) step(0, 64'h0, 1, 64'(i * 8 + 4));
    step(1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 64'h0);
    step(1, 64'h0, 0, 64'h0);
    step(1, 64'h0, 0, 64'h0);

    // async reset with three entries in flight, then with flush pending
    do_reset();
    for (int i = 0; i < 3; i++) step(1, 64'h0, 0, 64'h0);
    mid_reset();
    for (int i = 0; i < 3; i++) step(1, 64'h0, 0, 64'h0);
    step(0, 64'h0, 1, 64'h77);
    mid_reset();

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0, 1:    p = 64'h0;
        2:       p = {$urandom(), $urandom()} & ~64'h3;
        default: p = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 3) * 4);
      endcase
      n = ($urandom_range(0, 3) != 0) ? head() : {$urandom(), $urandom()};
      step($urandom_range(0, 4) != 0, p, $urandom_range(0, 1) == 1, n);
    end
    step(0, 64'h0, 0, 64'h0);

    // mispredict counter saturation on the narrow instance
    for (int i = 1; i <= 5; i++) begin
      @(posedge clk); #1;
      bus2.en = 1'b1; bus2.resolve_valid = 1'b0;
      @(posedge clk); #1;
      bus2.en = 1'b0; bus2.resolve_valid = 1'b1; bus2.resolve_next_pc = 64'h1;
      @(posedge clk); #1;
      bus2.resolve_valid = 1'b0;
      check("sat_mispredict_count", 64'(bus2.mispredict_count), 64'((i < 3) ? i : 3));
    end

    @(negedge clk);
    #1;
    check("scoreboard_drained", 64'(exp_q.size()), 64'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
